// File: rtl/codificador_display_bcd_if.sv
// codificador_display_bcd_if
// Groups the segment input and the valid/ready result port of the
// 7-segment to BCD encoder.
//   master : the encoder (drives the result, reads the segments and ready)
//   slave  : the consumer/environment (drives the segments and ready)
interface codificador_display_bcd_if;
   logic [6:0] _bcd_display;   // segment lines, bit 0 = a ... bit 6 = g
   logic [3:0] bcd;            // decoded digit, 4'hF on error
   logic       bcd_valid;      // result held in the output register
   logic       bcd_ready;      // consumer accepts the result
   logic       bcd_error;      // accepted pattern is not a legal digit
   logic       overrun;        // sticky: a result was overwritten untransferred

   modport master (
      input  _bcd_display,
      input  bcd_ready,
      output bcd,
      output bcd_valid,
      output bcd_error,
      output overrun
   );

   modport slave (
      output _bcd_display,
      output bcd_ready,
      input  bcd,
      input  bcd_valid,
      input  bcd_error,
      input  overrun
   );
endinterface

// File: rtl/codificador_display_bcd.sv
// codificador_display_bcd
// Converts a 7-segment pattern back into a BCD digit. The segment lines are
// sampled every cycle, a candidate pattern must stay stable for STABLE_CYCLES
// samples before it is accepted, and each newly accepted non-blank pattern
// produces one result in a valid/ready output register.
// Optional feature macro: CODIFICADOR_SYNC_EN adds a two-flop synchronizer
// ahead of the sample register (latency +2 cycles).
module codificador_display_bcd #(
   parameter int STABLE_CYCLES = 4   // legal range 1..15
) (
   input  logic                      clk,
   input  logic                      rst,
   codificador_display_bcd_if.master bus
);

   localparam logic [3:0] STABLE_C = 4'(STABLE_CYCLES);
   localparam logic [6:0] BLANK    = 7'h00;

   // Pattern table; returns {error, digit}. Anything unlisted is an error.
   function automatic logic [4:0] decode_seg(input logic [6:0] seg);
      logic [4:0] res;
      case (seg)
         7'h3F:   res = 5'b0_0000;
         7'h06:   res = 5'b0_0001;
         7'h5B:   res = 5'b0_0010;
         7'h4F:   res = 5'b0_0011;
         7'h66:   res = 5'b0_0100;
         7'h6D:   res = 5'b0_0101;
         7'h7C:   res = 5'b0_0110;
         7'h07:   res = 5'b0_0111;
         7'h7F:   res = 5'b0_1000;
         7'h67:   res = 5'b0_1001;
         default: res = 5'b1_1111;
      endcase
      return res;
   endfunction

   logic [6:0] raw_s;
   logic [6:0] sample_q, sample_d;
   logic [6:0] cand_q,   cand_d;
   logic [6:0] last_q,   last_d;
   logic [3:0] cnt_q,    cnt_d;
   logic [3:0] bcd_q,    bcd_d;
   logic       err_q,    err_d;
   logic       valid_q,  valid_d;
   logic       ovr_q,    ovr_d;
   logic       accept_s;
   logic       result_s;
   logic       xfer_s;
   logic [4:0] decoded_s;

`ifdef CODIFICADOR_SYNC_EN
   logic [6:0] sync1_q;
   logic [6:0] sync2_q;

   // Two-flop synchronizer for segment lines asynchronous to clk.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 7'h00;
         sync2_q <= 7'h00;
      end else begin
         sync1_q <= bus._bcd_display;
         sync2_q <= sync1_q;
      end
   end

   assign raw_s = sync2_q;
`else
   assign raw_s = bus._bcd_display;
`endif

   // Stability filter, acceptance decision and output register next state.
   always_comb begin
      sample_d  = raw_s;
      cand_d    = cand_q;
      cnt_d     = cnt_q;
      last_d    = last_q;
      bcd_d     = bcd_q;
      err_d     = err_q;
      valid_d   = valid_q;
      ovr_d     = ovr_q;
      decoded_s = decode_seg(cand_q);
      xfer_s    = valid_q & bus.bcd_ready;

      // A changed sample restarts the count; a repeat counts up to saturation.
      if (sample_q != cand_q) begin
         cand_d = sample_q;
         cnt_d  = 4'd1;
      end else if (cnt_q < STABLE_C) begin
         cnt_d = cnt_q + 4'd1;
      end else begin
         cnt_d = cnt_q;
      end

      // The counter saturates, so comparing with last_accepted keeps a held
      // pattern from being reported more than once.
      accept_s = (cnt_q == STABLE_C) && (cand_q != last_q);
      result_s = accept_s && (cand_q != BLANK);

      if (accept_s) begin
         last_d = cand_q;
      end else begin
         last_d = last_q;
      end

      // A new result always wins over a same-edge transfer.
      if (result_s) begin
         bcd_d   = decoded_s[3:0];
         err_d   = decoded_s[4];
         valid_d = 1'b1;
         if (valid_q && !bus.bcd_ready) begin
            ovr_d = 1'b1;
         end else begin
            ovr_d = ovr_q;
         end
      end else if (xfer_s) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // All filter and output state; rst discards any partial count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sample_q <= 7'h00;
         cand_q   <= 7'h00;
         last_q   <= 7'h00;
         cnt_q    <= 4'd0;
         bcd_q    <= 4'd0;
         err_q    <= 1'b0;
         valid_q  <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         sample_q <= sample_d;
         cand_q   <= cand_d;
         last_q   <= last_d;
         cnt_q    <= cnt_d;
         bcd_q    <= bcd_d;
         err_q    <= err_d;
         valid_q  <= valid_d;
         ovr_q    <= ovr_d;
      end
   end

   assign bus.bcd       = bcd_q;
   assign bus.bcd_error = err_q;
   assign bus.bcd_valid = valid_q;
   assign bus.overrun   = ovr_q;

endmodule

// File: tb/tb_codificador_display_bcd.sv
// Directed self-checking bench for codificador_display_bcd
// (STABLE_CYCLES = 4, default build without the synchronizer).
module tb_codificador_display_bcd;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   codificador_display_bcd_if bus ();

   codificador_display_bcd #(.STABLE_CYCLES(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;

   logic [3:0] res_bcd[$];
   logic       res_err[$];

   logic [6:0] pat [10];

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock edge per iteration; outputs are sampled on the falling edge,
   // and every transfer (valid && ready) is recorded.
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.bcd_valid === 1'b1 && bus.bcd_ready === 1'b1) begin
            res_bcd.push_back(bus.bcd);
            res_err.push_back(bus.bcd_error);
         end
      end
   endtask

   task automatic hold(input logic [6:0] p, input int n);
      bus._bcd_display = p;
      step(n);
   endtask

   task automatic clear_results();
      res_bcd.delete();
      res_err.delete();
   endtask

   initial begin
      pat[0] = 7'h3F; pat[1] = 7'h06; pat[2] = 7'h5B; pat[3] = 7'h4F; pat[4] = 7'h66;
      pat[5] = 7'h6D; pat[6] = 7'h7C; pat[7] = 7'h07; pat[8] = 7'h7F; pat[9] = 7'h67;

      rst = 1'b1;
      bus._bcd_display = 7'h00;
      bus.bcd_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("rst_bcd",     8'(bus.bcd),       8'h0);
      check("rst_valid",   8'(bus.bcd_valid), 8'h0);
      check("rst_error",   8'(bus.bcd_error), 8'h0);
      check("rst_overrun", 8'(bus.overrun),   8'h0);

      // Test 1: 5B held from before edge 1 -> valid after edge 6.
      rst = 1'b0;
      bus._bcd_display = 7'h5B;
      step(5);
      check("t1_valid_e5", 8'(bus.bcd_valid), 8'h0);
      step(1);
      check("t1_valid_e6", 8'(bus.bcd_valid), 8'h1);
      check("t1_bcd",      8'(bus.bcd),       8'h2);
      check("t1_error",    8'(bus.bcd_error), 8'h0);
      step(1);
      check("t1_valid_e7", 8'(bus.bcd_valid), 8'h0);
      clear_results();
      step(20);
      check("t1_no_repeat", 8'(res_bcd.size()), 8'd0);

      // Test 2: all ten legal digits in order.
      clear_results();
      for (int i = 0; i < 10; i++) begin
         hold(pat[i], 10);
      end
      check("t2_count", 8'(res_bcd.size()), 8'd10);
      for (int i = 0; i < 10 && i < res_bcd.size(); i++) begin
         check($sformatf("t2_bcd%0d", i), 8'(res_bcd[i]), 8'(i));
         check($sformatf("t2_err%0d", i), 8'(res_err[i]), 8'h0);
      end

      // Test 3: short 67 glitch back to the accepted 7C is never reported.
      clear_results();
      hold(7'h7C, 10);
      hold(7'h67, 2);
      hold(7'h7C, 10);
      check("t3_count", 8'(res_bcd.size()), 8'd1);
      if (res_bcd.size() > 0) check("t3_bcd", 8'(res_bcd[0]), 8'h6);

      // Test 4: a blank between two 4F gives two results, none for the blank.
      clear_results();
      hold(7'h4F, 10);
      hold(7'h00, 8);
      hold(7'h4F, 10);
      check("t4_count", 8'(res_bcd.size()), 8'd2);
      if (res_bcd.size() > 1) begin
         check("t4_bcd0", 8'(res_bcd[0]), 8'h3);
         check("t4_bcd1", 8'(res_bcd[1]), 8'h3);
         check("t4_err1", 8'(res_err[1]), 8'h0);
      end

      // Test 5: illegal pattern, then overrun with the consumer stalled.
      clear_results();
      hold(7'h49, 10);
      check("t5_ill_count", 8'(res_bcd.size()), 8'd1);
      if (res_bcd.size() > 0) begin
         check("t5_ill_bcd", 8'(res_bcd[0]), 8'hF);
         check("t5_ill_err", 8'(res_err[0]), 8'h1);
      end
      bus.bcd_ready = 1'b0;
      hold(7'h06, 10);
      check("t5_one_valid",   8'(bus.bcd_valid), 8'h1);
      check("t5_one_bcd",     8'(bus.bcd),       8'h1);
      check("t5_one_overrun", 8'(bus.overrun),   8'h0);
      hold(7'h66, 10);
      check("t5_four_valid",   8'(bus.bcd_valid), 8'h1);
      check("t5_four_bcd",     8'(bus.bcd),       8'h4);
      check("t5_four_err",     8'(bus.bcd_error), 8'h0);
      check("t5_four_overrun", 8'(bus.overrun),   8'h1);
      bus.bcd_ready = 1'b1;
      step(1);
      check("t5_xfer_valid", 8'(bus.bcd_valid), 8'h0);
      step(3);
      check("t5_sticky_overrun", 8'(bus.overrun), 8'h1);

      // Test 6: reset mid-count clears outputs at once; 6D then at nominal latency.
      bus._bcd_display = 7'h6D;
      step(3);
      rst = 1'b1;
      #1;
      check("t6_rst_bcd",     8'(bus.bcd),       8'h0);
      check("t6_rst_valid",   8'(bus.bcd_valid), 8'h0);
      check("t6_rst_error",   8'(bus.bcd_error), 8'h0);
      check("t6_rst_overrun", 8'(bus.overrun),   8'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      step(5);
      check("t6_valid_e5", 8'(bus.bcd_valid), 8'h0);
      step(1);
      check("t6_valid_e6", 8'(bus.bcd_valid), 8'h1);
      check("t6_bcd",      8'(bus.bcd),       8'h5);
      check("t6_error",    8'(bus.bcd_error), 8'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
